// File: rtl/branch_redirect_unit_pkg.sv
// Shared constants for the branch redirect unit: funct3 branch-condition
// codes, default sizing, and the branch comparison helper.
package branch_redirect_unit_pkg;

    localparam int DEFAULT_NUM_THREADS   = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // 010 and 011 are reserved encodings and never resolve as taken.
    function automatic logic branch_cond(input logic [2:0]  funct3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        case (funct3)
            F3_BEQ:  branch_cond = (a == b);
            F3_BNE:  branch_cond = (a != b);
            F3_BLT:  branch_cond = ($signed(a) <  $signed(b));
            F3_BGE:  branch_cond = ($signed(a) >= $signed(b));
            F3_BLTU: branch_cond = (a <  b);
            F3_BGEU: branch_cond = (a >= b);
            default: branch_cond = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/redirect_fifo.sv
// In-order queue of pending PC redirects with a sticky drop flag.
// QDEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module redirect_fifo #(
    parameter int WIDTH  = 35,
    parameter int QDEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head_data,
    output logic             overflow
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    assign empty     = (count == '0);
    assign full      = (count == CW'(QDEPTH));
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign do_push   = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & ~do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Resolves execute-stage branches/jumps for a barrel core and queues the
// resulting per-thread PC redirects toward the PC file.
module branch_redirect_unit
    import branch_redirect_unit_pkg::*;
#(
    parameter int NUM_THREADS   = DEFAULT_NUM_THREADS,
    parameter int BITS_THREADS  = $clog2(NUM_THREADS),
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int QDEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_e,
    input  logic [BITS_THREADS-1:0]  tid_e,
    input  logic                     branch_e,
    input  logic                     jump_e,
    input  logic                     jalr_e,
    input  logic [2:0]               funct3_e,
    input  logic [31:0]              rs1_e,
    input  logic [31:0]              rs2_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_e,
    input  logic [31:0]              imm_e,
    input  logic                     pc_ready,
    output logic                     pc_src_e,
    output logic [BITS_THREADS-1:0]  branch_tid_e,
    output logic [ADDRESS_WIDTH-1:0] pc_target_e,
    output logic                     misalign_e,
    output logic [BITS_THREADS-1:0]  misalign_tid,
    output logic                     overflow_err
);

    localparam int EW = BITS_THREADS + ADDRESS_WIDTH;

    logic                     taken;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [ADDRESS_WIDTH-1:0] pc_rel_target;
    logic [ADDRESS_WIDTH-1:0] jalr_target;
    logic [31:0]              jalr_sum;
    logic                     is_misaligned;
    logic                     push;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [EW-1:0]            head;

    assign pc_rel_target = pc_e + ADDRESS_WIDTH'(imm_e);
    assign jalr_sum      = rs1_e + imm_e;

    always_comb begin
        jalr_target    = ADDRESS_WIDTH'(jalr_sum);
        jalr_target[0] = 1'b0;
    end

    // Priority: JALR over JAL over conditional branch.
    always_comb begin
        taken  = 1'b0;
        target = pc_rel_target;
        if (valid_e) begin
            if (jalr_e) begin
                taken  = 1'b1;
                target = jalr_target;
            end else if (jump_e) begin
                taken  = 1'b1;
            end else if (branch_e) begin
                taken  = branch_cond(funct3_e, rs1_e, rs2_e);
            end
        end
    end

    assign is_misaligned = taken & target[1];
    assign push          = taken & ~target[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_e   <= 1'b0;
            misalign_tid <= '0;
        end else begin
            misalign_e <= is_misaligned;
            if (is_misaligned) begin
                misalign_tid <= tid_e;
            end
        end
    end

    redirect_fifo #(
        .WIDTH  (EW),
        .QDEPTH (QDEPTH)
    ) u_redirect_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({tid_e, target}),
        .pop       (pc_ready),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head_data (head),
        .overflow  (overflow_err)
    );

    assign pc_src_e     = ~fifo_empty;
    assign branch_tid_e = pc_src_e ? head[EW-1 -: BITS_THREADS] : '0;
    assign pc_target_e  = pc_src_e ? head[ADDRESS_WIDTH-1:0]    : '0;

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench: the driver predicts redirects from the architectural
// rules and queues them; a negedge monitor checks every handshake in order.
module tb_branch_redirect_unit;

    localparam int QD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_e = 1'b0;
    logic [2:0]  tid_e = '0;
    logic        branch_e = 1'b0;
    logic        jump_e = 1'b0;
    logic        jalr_e = 1'b0;
    logic [2:0]  funct3_e = '0;
    logic [31:0] rs1_e = '0;
    logic [31:0] rs2_e = '0;
    logic [31:0] pc_e = '0;
    logic [31:0] imm_e = '0;
    logic        pc_ready = 1'b0;
    logic        pc_src_e;
    logic [2:0]  branch_tid_e;
    logic [31:0] pc_target_e;
    logic        misalign_e;
    logic [2:0]  misalign_tid;
    logic        overflow_err;

    branch_redirect_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_e      (valid_e),
        .tid_e        (tid_e),
        .branch_e     (branch_e),
        .jump_e       (jump_e),
        .jalr_e       (jalr_e),
        .funct3_e     (funct3_e),
        .rs1_e        (rs1_e),
        .rs2_e        (rs2_e),
        .pc_e         (pc_e),
        .imm_e        (imm_e),
        .pc_ready     (pc_ready),
        .pc_src_e     (pc_src_e),
        .branch_tid_e (branch_tid_e),
        .pc_target_e  (pc_target_e),
        .misalign_e   (misalign_e),
        .misalign_tid (misalign_tid),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  tid;
        logic [31:0] tgt;
    } exp_t;

    exp_t       exp_q[$];
    int         cur_occ = 0;
    bit         exp_mis = 1'b0;
    logic [2:0] exp_mis_tid = '0;
    bit         exp_ovf = 1'b0;
    int         total = 0;
    int         bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: inputs are stable at the falling edge, so a redirect seen
    // here with pc_ready high is consumed at the following rising edge.
    always @(negedge clk) begin
        exp_t e;
        chk("pc_src_e", pc_src_e, cur_occ > 0);
        chk("overflow_err", overflow_err, exp_ovf);
        chk("misalign_e", misalign_e, exp_mis);
        if (exp_mis) chk("misalign_tid", misalign_tid, exp_mis_tid);
        if (!pc_src_e) begin
            chk("idle_tid_zero", branch_tid_e, 0);
            chk("idle_target_zero", pc_target_e, 0);
        end else if (pc_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_redirect: actual tid=%0d target=%0h required none", branch_tid_e, pc_target_e);
            end else begin
                e = exp_q.pop_front();
                chk("redirect_tid", branch_tid_e, e.tid);
                chk("redirect_target", pc_target_e, e.tgt);
            end
        end
    end

    // Applies one cycle of stimulus, predicts its effect, then advances past the edge.
    task automatic drive(input bit v, input logic [2:0] t, input bit br, input bit j,
                         input bit jr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] im,
                         input bit rdy);
        bit          cnd;
        bit          tk;
        logic [31:0] tg;
        int          pop_n;
        int          push_n;
        bit          nxt_mis;
        bit          nxt_ovf;
        valid_e = v; tid_e = t; branch_e = br; jump_e = j; jalr_e = jr;
        funct3_e = f3; rs1_e = a; rs2_e = b; pc_e = pc; imm_e = im; pc_ready = rdy;
        case (f3)
            3'd0:    cnd = (a == b);
            3'd1:    cnd = (a != b);
            3'd4:    cnd = ($signed(a) < $signed(b));
            3'd5:    cnd = !($signed(a) < $signed(b));
            3'd6:    cnd = (a < b);
            3'd7:    cnd = !(a < b);
            default: cnd = 1'b0;
        endcase
        tk = v && (jr || j || (br && cnd));
        tg = jr ? ((a + im) & 32'hFFFF_FFFE) : (pc + im);
        pop_n   = (cur_occ > 0 && rdy) ? 1 : 0;
        push_n  = 0;
        nxt_mis = 1'b0;
        nxt_ovf = 1'b0;
        if (tk && tg[1]) begin
            nxt_mis = 1'b1;
        end else if (tk) begin
            if (cur_occ < QD || pop_n == 1) begin
                exp_q.push_back('{t, tg});
                push_n = 1;
            end else begin
                nxt_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cur_occ = cur_occ - pop_n + push_n;
        exp_mis = nxt_mis;
        if (nxt_mis) exp_mis_tid = t;
        exp_ovf = exp_ovf | nxt_ovf;
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, rdy);
    endtask

    task automatic jal(input logic [2:0] t, input logic [31:0] pc, input logic [31:0] im, input bit rdy);
        drive(1'b1, t, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0, pc, im, rdy);
    endtask

    // Asserts reset away from any clock edge and checks the immediate clear.
    task automatic do_reset();
        valid_e = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        cur_occ = 0;
        exp_mis = 1'b0;
        exp_ovf = 1'b0;
        #1;
        chk("reset_pc_src", pc_src_e, 0);
        chk("reset_target", pc_target_e, 0);
        chk("reset_ovf", overflow_err, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a, b, im, pc;
        #1;
        do_reset();
        chk("reset_misalign", misalign_e, 0);

        // BEQ taken, one-cycle latency
        drive(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        chk("beq_src", pc_src_e, 1);
        chk("beq_tid", branch_tid_e, 3);
        chk("beq_target", pc_target_e, 32'h120);
        idle(1'b1);
        chk("beq_src_after", pc_src_e, 0);

        // Signed vs unsigned less-than
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1);
        chk("blt_target", pc_target_e, 32'h210);
        drive(1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1);
        chk("bltu_no_src", pc_src_e, 0);

        // Misaligned JALR
        drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd0, 32'h203, 32'd0, 32'h300, 32'd0, 1'b1);
        chk("jalr_mis", misalign_e, 1);
        chk("jalr_mis_tid", misalign_tid, 5);
        chk("jalr_no_src", pc_src_e, 0);
        idle(1'b1);
        chk("jalr_mis_pulse", misalign_e, 0);

        // Target wraps around the address space
        jal(3'd6, 32'hFFFF_FFF0, 32'h20, 1'b1);
        chk("wrap_target", pc_target_e, 32'h10);
        idle(1'b1);

        // Full queue with simultaneous pop and push: no drop
        for (int i = 0; i < 4; i++) jal(3'(i), 32'h1000 + 32'(i * 16), 32'h40, 1'b0);
        jal(3'd4, 32'h2000, 32'h40, 1'b1);
        chk("simul_no_ovf", overflow_err, 0);
        chk("simul_head", branch_tid_e, 1);
        repeat (4) idle(1'b1);
        chk("simul_drained", pc_src_e, 0);

        // Overflow: five pushes into a stalled queue
        for (int i = 0; i < 5; i++) jal(3'(i), 32'h3000, 32'(i * 4), 1'b0);
        chk("ovf_set", overflow_err, 1);
        chk("ovf_head", branch_tid_e, 0);
        repeat (4) idle(1'b1);
        chk("ovf_drained", pc_src_e, 0);
        chk("ovf_sticky", overflow_err, 1);

        // Reset with two entries queued, then first push after reset
        do_reset();
        jal(3'd1, 32'h400, 32'h8, 1'b0);
        jal(3'd2, 32'h500, 32'h8, 1'b0);
        do_reset();
        jal(3'd7, 32'h600, 32'h4, 1'b1);
        chk("post_reset_src", pc_src_e, 1);
        chk("post_reset_target", pc_target_e, 32'h604);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            a  = $urandom();
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
            im = $urandom();
            pc = $urandom();
            if ($urandom_range(0, 3) != 0) begin
                im = im & 32'hFFFF_FFFC;
                pc = pc & 32'hFFFF_FFFC;
                a  = a & 32'hFFFF_FFFC;
            end
            drive($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
                  a, b, pc, im, 1'($urandom_range(0, 1)));
        end
        for (int n = 0; n < 10 && cur_occ > 0; n++) idle(1'b1);
        chk("final_drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_redirect_unit.md
BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 Parameters SHALL be: NUM_THREADS, default 8, number of barrel threads; BITS_THREADS, default $clog2(NUM_THREADS), thread-id width; ADDRESS_WIDTH, default 32, PC width; QDEPTH, default 4, redirect queue depth (power of two).
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; all state is clocked on the rising clk edge.
REQ-003 Ports SHALL be as listed below (name, direction, width, meaning).
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- valid_e  in  1  execute-stage instruction valid
- tid_e  in  BITS_THREADS  owning thread of the execute instruction
- branch_e  in  1  conditional branch
- jump_e  in  1  JAL
- jalr_e  in  1  JALR
- funct3_e  in  3  branch condition
- rs1_e, rs2_e  in  32  operands
- pc_e  in  ADDRESS_WIDTH  instruction PC
- imm_e  in  32  sign-extended immediate
- pc_ready  in  1  PC file accepts a redirect write this cycle
- pc_src_e  out  1  redirect valid to the per-thread PC file
- branch_tid_e  out  BITS_THREADS  thread to redirect
- pc_target_e  out  ADDRESS_WIDTH  new PC for that thread
- misalign_e  out  1  one-cycle pulse: taken target misaligned
- misalign_tid  out  BITS_THREADS  thread of the misaligned target
- overflow_err  out  1  sticky: redirect dropped because the queue was full

Function
REQ-004 Taken SHALL be defined as valid_e & (jalr_e | jump_e | (branch_e & cond)); jalr_e has priority over jump_e, and jump_e over branch_e.
REQ-005 cond SHALL be decoded from funct3_e: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge; 010 and 011 never taken.
REQ-006 Target SHALL be pc_e+imm_e for branch and JAL, and (rs1_e+imm_e) with bit0 cleared for JALR; the sum wraps modulo 2^ADDRESS_WIDTH.
REQ-007 A taken target with bit1 set SHALL NOT be enqueued; instead misalign_e is registered high for exactly one cycle, with misalign_tid set to tid_e.
REQ-008 An aligned taken redirect SHALL be pushed at the clock edge into a QDEPTH-entry FIFO of {tid, target}.
REQ-009 pc_src_e SHALL equal FIFO non-empty; branch_tid_e and pc_target_e SHALL present the head entry.
REQ-010 The head SHALL pop on a clock edge where pc_src_e & pc_ready; entries are never reordered.
REQ-011 Latency SHALL be exactly one cycle from a taken execute instruction to pc_src_e when the FIFO was empty.
REQ-012 On simultaneous push and pop the count SHALL be unchanged; this is legal even when full.
REQ-013 A push with the FIFO full and no pop SHALL drop the new entry and set overflow_err, which stays set until reset.
REQ-014 Read and write pointers SHALL wrap modulo QDEPTH; full and empty are derived from an occupancy counter ranging 0..QDEPTH.
REQ-015 When pc_src_e is low, branch_tid_e and pc_target_e SHALL be driven to 0.

Reset
REQ-016 While rst is low the block SHALL clear the pointers, counter, entries, misalign_e, misalign_tid and overflow_err; all outputs then read 0.
REQ-017 Reset asserted mid-operation SHALL discard all queued redirects immediately (asynchronously).
REQ-018 The first push SHALL be accepted on the first rising edge after rst rises.

Structure
REQ-019 A shared package SHALL hold the funct3 branch-condition constants and the default NUM_THREADS and ADDRESS_WIDTH values.
REQ-020 The queue SHALL be a sub-module redirect_fifo, parameterised by width and QDEPTH.

Verification
REQ-021 Scenario: BEQ with tid 3, pc 0x100, imm 0x20, rs1=rs2=5, pc_ready=1 -> next cycle pc_src_e=1, tid 3, target 0x120; low the cycle after.
REQ-022 Scenario: BLT with rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> no redirect.
REQ-023 Scenario: JALR with rs1=0x203, imm 0 -> target 0x202 is misaligned -> misalign_e pulses for one cycle, misalign_tid correct, no pc_src_e.
REQ-024 Scenario: pc_ready=0, five JALs from tids 0..4 -> four queued and overflow_err=1; raise pc_ready -> tids 0,1,2,3 drain in order over four cycles.
REQ-025 Scenario: queue full with pc_ready=1 and a new push in the same cycle -> count stays 4 and no overflow_err.
REQ-026 Scenario: pc 0xFFFFFFF0, imm 0x20 -> target 0x00000010 (wrap); rst pulsed low with 2 entries queued -> pc_src_e=0 immediately.
